systolic_pe_os: RTL and testbench
=================================

Name: systolic_pe_os

Overview:
- Second-generation output-stationary processing element for the systolic matrix-multiply array.
- Adds to the basic MAC-and-forward cell:
  - valid qualification on both operand streams;
  - a tile-boundary "last" marker;
  - a double-buffered result register;
  - a per-column drain shift chain, so results are read out while the next tile accumulates.
- Instantiated ARRAY_ROWS x ARRAY_COLS times by the array top. Operands flow west->east and north->south; results shift north->south on the drain chain.

Parameters:
- DATA_W, 8, operand width in bits.
- K_MAX, 16, maximum operand pairs per tile; sizes the accumulator.
- ACC_W, 2*DATA_W+$clog2(K_MAX), accumulator/result width.
- SIGNED, 1: 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset.
- a_in, in, DATA_W, west operand.
- a_vld_in, in, 1, a_in valid.
- last_in, in, 1, marks final pair of a tile; travels with a.
- b_in, in, DATA_W, north operand.
- b_vld_in, in, 1, b_in valid.
- a_out, out, DATA_W, registered a_in to east neighbour.
- a_vld_out, out, 1, registered a_vld_in.
- last_out, out, 1, registered last_in.
- b_out, out, DATA_W, registered b_in to south neighbour.
- b_vld_out, out, 1, registered b_vld_in.
- drain_shift, in, 1, column-wide drain strobe.
- drain_in, in, ACC_W, result from north PE (0 at the top row).
- drain_vld_in, in, 1, drain_in valid.
- drain_out, out, ACC_W, result register toward south.
- drain_vld_out, out, 1, result register valid.
- err, out, 1, sticky overrun flag.

Behaviour:
- Reset: rst is synchronous and active-high on clk. On reset, every output register, acc and err go to 0. A reset mid-tile discards the partial sum and any held result.

Forwarding:
- a_out/a_vld_out/last_out and b_out/b_vld_out are registered copies of their inputs. Latency is 1 cycle, and they update every cycle regardless of valid.
- Data is forwarded even when its valid is low. Downstream cells ignore it.

MAC:
- fire = a_vld_in & b_vld_in.
- product = a_in*b_in, full 2*DATA_W width, signed or unsigned per SIGNED, then sign/zero-extended to ACC_W.
- If fire and !last_in: acc <= acc + product.
- If fire and last_in (completion):
  - res <= acc + product;
  - res_vld <= 1;
  - acc <= 0, the same cycle.
  - The next tile may fire in the following cycle with zero bubbles.
- A single valid without the other: no MAC, no error.
- last_in with fire low: ignored.

Drain:
- drain_out = res and drain_vld_out = res_vld, driven directly from registers.
- If drain_shift and no completion: res <= drain_in, res_vld <= drain_vld_in.
- A column of N PEs empties its N results in N drain_shift cycles, bottom row first.

Collisions and errors:
- Completion while res_vld=1 and no drain_shift: res is overwritten, err <= 1.
- Completion and drain_shift in the same cycle: completion wins res. The drain_in word is lost, so err <= 1 if drain_vld_in=1.
- err clears only on rst.

Arithmetic without SAT_EN: acc and res wrap modulo 2^ACC_W.

Optional Feature:
- Macro: PE_SAT_EN.
- Defined: every accumulate and completion sum saturates to the ACC_W range (signed or unsigned per SIGNED) instead of wrapping. A sticky sat flag is ORed into err.
- Undefined: wrap-around, and err reflects overruns only.

Decomposition:
- Shared package systolic_pkg holds:
  - DATA_W and K_MAX defaults;
  - the ACC_W derivation function;
  - the operand-beat typedef {data, vld, last}, used by the array top and the feeder.
- One natural sub-module: pe_mac_acc, containing the multiply, extension, optional saturation, acc/res registers and the completion/drain mux. The top cell adds forwarding registers and error logic.

Test Plan:
- Forwarding: a_in=5 vld=1 last=1, b_in=-3 vld=1 -> next cycle a_out=5, last_out=1, b_out=-3 (0xFD).
- Tile: pairs (2,3), (4,5), (-1,7) with last on the third pair -> drain_vld_out=1 and drain_out=19 one cycle after the third pair; acc=0.
- Back-to-back tile: second tile (1,1), (1,1)-last starts the cycle after completion. Assert drain_shift with drain_in=0, vld=0 between completions -> second result 2 appears, err=0.
- Overrun: two completions with no drain_shift -> err=1, drain_out holds the second result, err persists until rst.
- Drain chain: 3-PE column holding results 10, 20, 30 (top to bottom), three drain_shift cycles -> bottom drain_out sequence 30, 20, 10, then drain_vld_out=0.
- Overflow: SIGNED=1, DATA_W=8, K_MAX=2 (ACC_W=17), four pairs of (-128,-128)=16384 each:
  - without PE_SAT_EN: result = 65536 mod 2^17 = -65536;
  - with PE_SAT_EN: result = 65535 and err=1.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the output-stationary systolic array:
// default operand sizing, accumulator width derivation and the
// operand-beat type used by the array top and the operand feeders.
package systolic_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int K_MAX_DEF  = 16;

  // Full-precision product plus enough headroom for K_MAX additions.
  function automatic int acc_width(input int data_w, input int k_max);
    return 2 * data_w + $clog2(k_max);
  endfunction

  // One operand beat as it travels along a row or column.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  vld;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/pe_mac_acc.sv
// Multiply-accumulate core of the output-stationary PE.
// Holds the running accumulator and the double-buffered result register,
// and muxes between tile completion and the drain shift chain.
// Optional saturation is compiled in with the PE_SAT_EN macro; without it
// every sum wraps modulo 2^ACC_W.
module pe_mac_acc
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = acc_width(DATA_W_DEF, K_MAX_DEF),
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              fire,
  input  logic              last,
  input  logic              drain_shift,
  input  logic [ACC_W-1:0]  drain_in,
  input  logic              drain_vld_in,
  output logic [ACC_W-1:0]  res,
  output logic              res_vld,
  output logic              completion,
  output logic              sat_hit
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W - PROD_W;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;

  // Full-width product, sign- or zero-extended to the accumulator width.
  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [PROD_W-1:0] prod;
      assign prod     = $signed(a) * $signed(b);
      assign prod_ext = {{EXT_W{prod[PROD_W-1]}}, prod};
    end else begin : g_unsigned
      logic [PROD_W-1:0] prod;
      assign prod     = a * b;
      assign prod_ext = {{EXT_W{1'b0}}, prod};
    end
  endgenerate

`ifdef PE_SAT_EN
  logic [ACC_W:0]   sum_wide;
  logic             ovf;
  logic [ACC_W-1:0] sat_val;

  // Sum with one guard bit; clamp to the representable range on overflow.
  always_comb begin
    if (SIGNED != 0) begin
      sum_wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
      ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
      sat_val  = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      sum_wide = {1'b0, acc} + {1'b0, prod_ext};
      ovf      = sum_wide[ACC_W];
      sat_val  = {ACC_W{1'b1}};
    end
    sum     = ovf ? sat_val : sum_wide[ACC_W-1:0];
    sat_hit = fire & ovf;
  end
`else
  // Plain modular sum.
  always_comb begin
    sum     = acc + prod_ext;
    sat_hit = 1'b0;
  end
`endif

  assign completion = fire & last;

  // Accumulator: clears on completion so the next tile can start at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (completion) begin
      acc <= '0;
    end else if (fire) begin
      acc <= sum;
    end
  end

  // Result register: completion has priority over the drain shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      res     <= '0;
      res_vld <= 1'b0;
    end else if (completion) begin
      res     <= sum;
      res_vld <= 1'b1;
    end else if (drain_shift) begin
      res     <= drain_in;
      res_vld <= drain_vld_in;
    end
  end

endmodule

// File: rtl/systolic_pe_os.sv
// Output-stationary systolic processing element.
// Forwards both operand streams with one cycle of latency, accumulates
// valid operand pairs in pe_mac_acc, and flags result overruns in a
// sticky err bit. Define PE_SAT_EN to make sums saturate instead of wrap;
// saturation events are then also reported through err.
module systolic_pe_os
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K_MAX  = K_MAX_DEF,
  parameter int ACC_W  = acc_width(DATA_W, K_MAX),
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic              last_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic              last_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vld_out,
  input  logic              drain_shift,
  input  logic [ACC_W-1:0]  drain_in,
  input  logic              drain_vld_in,
  output logic [ACC_W-1:0]  drain_out,
  output logic              drain_vld_out,
  output logic              err
);

  logic fire;
  logic completion;
  logic sat_hit;
  logic overrun;

  assign fire = a_vld_in & b_vld_in;

  pe_mac_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .clk          (clk),
    .rst          (rst),
    .a            (a_in),
    .b            (b_in),
    .fire         (fire),
    .last         (last_in),
    .drain_shift  (drain_shift),
    .drain_in     (drain_in),
    .drain_vld_in (drain_vld_in),
    .res          (drain_out),
    .res_vld      (drain_vld_out),
    .completion   (completion),
    .sat_hit      (sat_hit)
  );

  // An overrun loses a result: either the held one (no shift to move it
  // south) or the incoming drain word (completion claims the register).
  assign overrun = completion &
                   ((drain_vld_out & ~drain_shift) | (drain_shift & drain_vld_in));

  // Operand forwarding: unconditional, downstream cells qualify by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= '0;
      a_vld_out <= 1'b0;
      last_out  <= 1'b0;
      b_out     <= '0;
      b_vld_out <= 1'b0;
    end else begin
      a_out     <= a_in;
      a_vld_out <= a_vld_in;
      last_out  <= last_in;
      b_out     <= b_in;
      b_vld_out <= b_vld_in;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (overrun | sat_hit) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_pe_os.sv
// Directed self-checking bench for systolic_pe_os: forwarding, tile
// accumulation, back-to-back tiles, overrun/collision errors, a 3-deep
// drain column and accumulator overflow (wrap or saturate by PE_SAT_EN).
module tb_systolic_pe_os;

  localparam int DW  = 8;
  localparam int AW  = 20;  // 2*8 + clog2(16)
  localparam int OAW = 17;  // 2*8 + clog2(2)

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- main PE ----------------
  logic [DW-1:0] a_in, b_in, a_out, b_out;
  logic          a_vld_in, b_vld_in, last_in, a_vld_out, b_vld_out, last_out;
  logic          drain_shift, drain_vld_in, drain_vld_out, err;
  logic [AW-1:0] drain_in, drain_out;

  systolic_pe_os dut (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_vld_in(a_vld_in), .last_in(last_in),
    .b_in(b_in), .b_vld_in(b_vld_in),
    .a_out(a_out), .a_vld_out(a_vld_out), .last_out(last_out),
    .b_out(b_out), .b_vld_out(b_vld_out),
    .drain_shift(drain_shift), .drain_in(drain_in), .drain_vld_in(drain_vld_in),
    .drain_out(drain_out), .drain_vld_out(drain_vld_out), .err(err)
  );

  // ---------------- overflow PE (K_MAX=2) ----------------
  logic [DW-1:0]  o_a, o_b, o_a_out, o_b_out;
  logic           o_vld, o_last, o_a_vld_out, o_b_vld_out, o_last_out;
  logic           o_dvld_out, o_err;
  logic [OAW-1:0] o_dout;

  systolic_pe_os #(.DATA_W(8), .K_MAX(2), .SIGNED(1)) dut_ovf (
    .clk(clk), .rst(rst),
    .a_in(o_a), .a_vld_in(o_vld), .last_in(o_last),
    .b_in(o_b), .b_vld_in(o_vld),
    .a_out(o_a_out), .a_vld_out(o_a_vld_out), .last_out(o_last_out),
    .b_out(o_b_out), .b_vld_out(o_b_vld_out),
    .drain_shift(1'b0), .drain_in('0), .drain_vld_in(1'b0),
    .drain_out(o_dout), .drain_vld_out(o_dvld_out), .err(o_err)
  );

  // ---------------- 3-PE drain column ----------------
  logic [DW-1:0] c_a [3];
  logic [DW-1:0] c_b [3];
  logic          c_vld, c_last, c_shift;
  logic [AW-1:0] c_dout [3];
  logic          c_dvld [3];
  logic [DW-1:0] c_a_out [3];
  logic [DW-1:0] c_b_out [3];
  logic          c_av [3];
  logic          c_bv [3];
  logic          c_lo [3];
  logic          c_err [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_col
      logic [AW-1:0] din;
      logic          dvin;
      if (gi == 0) begin : g_top
        assign din  = '0;
        assign dvin = 1'b0;
      end else begin : g_rest
        assign din  = c_dout[gi-1];
        assign dvin = c_dvld[gi-1];
      end
      systolic_pe_os u_pe (
        .clk(clk), .rst(rst),
        .a_in(c_a[gi]), .a_vld_in(c_vld), .last_in(c_last),
        .b_in(c_b[gi]), .b_vld_in(c_vld),
        .a_out(c_a_out[gi]), .a_vld_out(c_av[gi]), .last_out(c_lo[gi]),
        .b_out(c_b_out[gi]), .b_vld_out(c_bv[gi]),
        .drain_shift(c_shift), .drain_in(din), .drain_vld_in(dvin),
        .drain_out(c_dout[gi]), .drain_vld_out(c_dvld[gi]), .err(c_err[gi])
      );
    end
  endgenerate

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand pair (plus drain controls) into the main PE.
  task automatic pair(input logic [7:0] a, input logic [7:0] b, input logic av,
                      input logic bv, input logic l, input logic sh,
                      input logic [AW-1:0] din, input logic dv);
    a_in = a; b_in = b; a_vld_in = av; b_vld_in = bv; last_in = l;
    drain_shift = sh; drain_in = din; drain_vld_in = dv;
    step();
  endtask

  task automatic idle();
    pair(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    a_in = '0; b_in = '0; a_vld_in = 0; b_vld_in = 0; last_in = 0;
    drain_shift = 0; drain_in = '0; drain_vld_in = 0;
    o_a = '0; o_b = '0; o_vld = 0; o_last = 0;
    for (int i = 0; i < 3; i++) begin c_a[i] = '0; c_b[i] = '0; end
    c_vld = 0; c_last = 0; c_shift = 0;
    step(); step();
    chk("rst_a_out", 32'(a_out), 32'd0);
    chk("rst_dvld", 32'(drain_vld_out), 32'd0);
    chk("rst_dout", 32'(drain_out), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Single valid with last: no MAC, no error.
    pair(8'd9, 8'd9, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("single_vld_dvld", 32'(drain_vld_out), 32'd0);
    chk("single_vld_err", 32'(err), 32'd0);

    // Forwarding (also completes 5 * -3 = -15).
    pair(8'd5, 8'hFD, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("fwd_a_out", 32'(a_out), 32'd5);
    chk("fwd_last_out", 32'(last_out), 32'd1);
    chk("fwd_b_out", 32'(b_out), 32'hFD);
    chk("fwd_vlds", 32'({a_vld_out, b_vld_out}), 32'd3);
    chk("fwd_res", 32'(drain_out), 32'hFFFF1);
    // Shift the result out with an empty word from the north.
    pair(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    chk("fwd_drained_vld", 32'(drain_vld_out), 32'd0);

    // Tile (2,3),(4,5),(-1,7)-last -> 19.
    pair(8'd2, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    pair(8'd4, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("tile_mid_dvld", 32'(drain_vld_out), 32'd0);
    pair(8'hFF, 8'd7, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("tile_dvld", 32'(drain_vld_out), 32'd1);
    chk("tile_dout", 32'(drain_out), 32'd19);
    chk("tile_err", 32'(err), 32'd0);

    // Back-to-back tile with a drain shift between completions -> 2.
    pair(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1, '0, 1'b0);
    chk("b2b_shift_dvld", 32'(drain_vld_out), 32'd0);
    pair(8'd1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("b2b_dout", 32'(drain_out), 32'd2);
    chk("b2b_dvld", 32'(drain_vld_out), 32'd1);
    chk("b2b_err", 32'(err), 32'd0);

    // Overrun: completions while a result is held and nothing shifts.
    pair(8'd3, 8'd3, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("ovr1_err", 32'(err), 32'd1);
    chk("ovr1_dout", 32'(drain_out), 32'd9);
    pair(8'd2, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    chk("ovr2_dout", 32'(drain_out), 32'd4);
    idle(); idle(); idle();
    chk("ovr_sticky_err", 32'(err), 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("ovr_rst_err", 32'(err), 32'd0);
    chk("ovr_rst_dvld", 32'(drain_vld_out), 32'd0);

    // Completion collides with a valid drain word: completion wins, err set.
    pair(8'd1, 8'd2, 1'b1, 1'b1, 1'b1, 1'b1, 20'd77, 1'b1);
    chk("coll_dout", 32'(drain_out), 32'd2);
    chk("coll_err", 32'(err), 32'd1);
    idle();
    rst = 1'b1; step(); rst = 1'b0;

    // Drain column: load 10, 20, 30 top to bottom, then shift three times.
    c_a[0] = 8'd2; c_b[0] = 8'd5;
    c_a[1] = 8'd4; c_b[1] = 8'd5;
    c_a[2] = 8'd5; c_b[2] = 8'd6;
    c_vld = 1; c_last = 1;
    step();
    c_vld = 0; c_last = 0;
    chk("col_bot0", 32'(c_dout[2]), 32'd30);
    c_shift = 1;
    step();
    chk("col_bot1", 32'(c_dout[2]), 32'd20);
    step();
    chk("col_bot2", 32'(c_dout[2]), 32'd10);
    chk("col_bot2_vld", 32'(c_dvld[2]), 32'd1);
    step();
    c_shift = 0;
    chk("col_bot3_vld", 32'(c_dvld[2]), 32'd0);
    chk("col_err", 32'({c_err[0], c_err[1], c_err[2]}), 32'd0);

    // Overflow: four (-128,-128) pairs = 65536 in a 17-bit signed acc.
    o_a = 8'h80; o_b = 8'h80; o_vld = 1;
    for (int i = 0; i < 4; i++) begin
      o_last = (i == 3);
      step();
    end
    o_vld = 0; o_last = 0;
    chk("ovf_dvld", 32'(o_dvld_out), 32'd1);
`ifdef PE_SAT_EN
    chk("ovf_dout", 32'(o_dout), 32'h0FFFF);
    chk("ovf_err", 32'(o_err), 32'd1);
`else
    chk("ovf_dout", 32'(o_dout), 32'h10000);
    chk("ovf_err", 32'(o_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
